// File: rtl/multi_key_debounce.sv
// rtl/multi_key_debounce.sv - N-channel push-button debouncer with hysteresis, exclusive qualify and auto-repeat
//
// Ports:
//   sysclk     in   1     system clock, all logic on posedge
//   reset      in   1     asynchronous, active-high; clears all state
//   key_in     in   N_CH  raw button inputs (asynchronous, active-high)
//   key_level  out  N_CH  debounced key level
//   press      out  N_CH  1-cycle pulse on the edge key_level rises
//   released   out  N_CH  1-cycle pulse on the edge key_level falls
//   rpt        out  N_CH  1-cycle auto-repeat pulse while a key is held

module multi_key_debounce #(
   parameter int N_CH       = 3,
   parameter int TICK_BITS  = 21,
   parameter int DEPTH      = 3,
   parameter int EXCLUSIVE  = 1,
   parameter int RPT_DELAY  = 32,
   parameter int RPT_PERIOD = 8
) (
   input  logic            sysclk,
   input  logic            reset,
   input  logic [N_CH-1:0] key_in,
   output logic [N_CH-1:0] key_level,
   output logic [N_CH-1:0] press,
   output logic [N_CH-1:0] released,
   output logic [N_CH-1:0] rpt
);

   localparam int RCW = $clog2(RPT_DELAY + 1);
   localparam logic [RCW-1:0] RC_TOP = RCW'(RPT_DELAY);
   // After a repeat pulse the counter restarts RPT_PERIOD ticks short of the
   // top, so it never has to wrap through zero.
   localparam logic [RCW-1:0] RC_RELOAD =
      (RPT_PERIOD >= RPT_DELAY) ? '0 : RCW'(RPT_DELAY - RPT_PERIOD);

   logic [TICK_BITS-1:0] tick_cnt;
   logic                 tick;
   logic [N_CH-1:0]      sync_1;
   logic [N_CH-1:0]      sync_2;
   logic [N_CH-1:0]      qual;
   logic [DEPTH-1:0]     shift_reg  [N_CH];
   logic [DEPTH-1:0]     shift_next [N_CH];
   logic [N_CH-1:0]      all_ones;
   logic [N_CH-1:0]      all_zeros;
   logic [RCW-1:0]       rc     [N_CH];
   logic [RCW-1:0]       rc_inc [N_CH];

   // A key only counts as pressed when no other synced key is high, so
   // chords never produce a press on any of their keys.
   function automatic logic [N_CH-1:0] qualify(input logic [N_CH-1:0] s);
      logic [N_CH-1:0] others;
      logic [N_CH-1:0] q;
      q = s;
      if (EXCLUSIVE != 0) begin
         for (int i = 0; i < N_CH; i++) begin
            others    = s;
            others[i] = 1'b0;
            q[i]      = s[i] & ~(|others);
         end
      end
      return q;
   endfunction

   assign tick = &tick_cnt;
   assign qual = qualify(sync_2);

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         shift_next[i] = {shift_reg[i][DEPTH-2:0], qual[i]};
         all_ones[i]   = &shift_next[i];
         all_zeros[i]  = ~(|shift_next[i]);
         rc_inc[i]     = rc[i] + 1'b1;
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         tick_cnt <= '0;
         sync_1   <= '0;
         sync_2   <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
         sync_1   <= key_in;
         sync_2   <= sync_1;
      end
   end

   // Level only moves on a fully uniform history; a mixed history holds the
   // current level, which is what gives the filter its hysteresis.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         key_level <= '0;
         press     <= '0;
         released  <= '0;
         rpt       <= '0;
         for (int i = 0; i < N_CH; i++) begin
            shift_reg[i] <= '0;
            rc[i]        <= '0;
         end
      end else begin
         press    <= '0;
         released <= '0;
         rpt      <= '0;
         if (tick) begin
            for (int i = 0; i < N_CH; i++) begin
               shift_reg[i] <= shift_next[i];
               if (!key_level[i] && all_ones[i]) begin
                  key_level[i] <= 1'b1;
                  press[i]     <= 1'b1;
                  rc[i]        <= '0;
               end else if (key_level[i] && all_zeros[i]) begin
                  key_level[i] <= 1'b0;
                  released[i]  <= 1'b1;
                  rc[i]        <= '0;
               end else if (key_level[i] && (RPT_PERIOD != 0)) begin
                  if (rc_inc[i] == RC_TOP) begin
                     rpt[i] <= 1'b1;
                     rc[i]  <= RC_RELOAD;
                  end else begin
                     rc[i] <= rc_inc[i];
                  end
               end else begin
                  rc[i] <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_key_debounce.sv
// tb/tb_multi_key_debounce.sv - self-checking bench for multi_key_debounce

module tb_multi_key_debounce;

   localparam int DEPTH = 3;
   localparam int DELAY = 4;
   localparam int EXCL_C [3] = '{1, 0, 1};
   localparam int PER_C  [3] = '{2, 2, 0};

   logic       sysclk = 1'b0;
   logic       reset  = 1'b1;
   logic [2:0] key_in = 3'b000;

   logic [2:0] lvl_a, prs_a, rel_a, rpt_a;
   logic [2:0] lvl_b, prs_b, rel_b, rpt_b;
   logic [2:0] lvl_c, prs_c, rel_c, rpt_c;

   int checks = 0;
   int errors = 0;

   always #5 sysclk = ~sysclk;

   multi_key_debounce #(.N_CH(3), .TICK_BITS(2), .DEPTH(DEPTH), .EXCLUSIVE(1),
                        .RPT_DELAY(DELAY), .RPT_PERIOD(2)) dut_a (
      .sysclk(sysclk), .reset(reset), .key_in(key_in),
      .key_level(lvl_a), .press(prs_a), .released(rel_a), .rpt(rpt_a));

   multi_key_debounce #(.N_CH(3), .TICK_BITS(2), .DEPTH(DEPTH), .EXCLUSIVE(0),
                        .RPT_DELAY(DELAY), .RPT_PERIOD(2)) dut_b (
      .sysclk(sysclk), .reset(reset), .key_in(key_in),
      .key_level(lvl_b), .press(prs_b), .released(rel_b), .rpt(rpt_b));

   multi_key_debounce #(.N_CH(3), .TICK_BITS(2), .DEPTH(DEPTH), .EXCLUSIVE(1),
                        .RPT_DELAY(DELAY), .RPT_PERIOD(0)) dut_c (
      .sysclk(sysclk), .reset(reset), .key_in(key_in),
      .key_level(lvl_c), .press(prs_c), .released(rel_c), .rpt(rpt_c));

   task automatic check_bits(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [35:0] all_outs();
      return {lvl_a, prs_a, rel_a, rpt_a, lvl_b, prs_b, rel_b, rpt_b,
              lvl_c, prs_c, rel_c, rpt_c};
   endfunction

   // Reference model: runs of identical samples per channel, ticks since
   // press, repeat when (ticks-DELAY) is a multiple of the period.
   int         edge_cnt;
   logic [2:0] m_s1, m_s2;
   bit         m_tick;
   bit         m_q;
   bit         run_val [3][3];
   int         run_len [3][3];
   int         tsp     [3][3];
   logic [2:0] e_lvl [3];
   logic [2:0] e_prs [3];
   logic [2:0] e_rel [3];
   logic [2:0] e_rpt [3];

   task automatic model_clear();
      edge_cnt = 0;
      m_s1 = 3'b000;
      m_s2 = 3'b000;
      for (int c = 0; c < 3; c++) begin
         e_lvl[c] = 3'b000; e_prs[c] = 3'b000; e_rel[c] = 3'b000; e_rpt[c] = 3'b000;
         for (int i = 0; i < 3; i++) begin
            run_val[c][i] = 1'b0;
            run_len[c][i] = DEPTH;
            tsp[c][i]     = 0;
         end
      end
   endtask

   always @(posedge sysclk or posedge reset) begin
      if (reset) begin
         model_clear();
      end else begin
         m_tick = (edge_cnt % 4) == 3;
         edge_cnt++;
         for (int c = 0; c < 3; c++) begin
            e_prs[c] = 3'b000; e_rel[c] = 3'b000; e_rpt[c] = 3'b000;
            if (m_tick) begin
               for (int i = 0; i < 3; i++) begin
                  m_q = m_s2[i] && (EXCL_C[c] == 0 || (m_s2 & ~(3'b001 << i)) == 3'b000);
                  if (m_q == run_val[c][i]) run_len[c][i]++;
                  else begin run_val[c][i] = m_q; run_len[c][i] = 1; end
                  if (run_len[c][i] >= DEPTH && run_val[c][i] && !e_lvl[c][i]) begin
                     e_lvl[c][i] = 1'b1; e_prs[c][i] = 1'b1; tsp[c][i] = 0;
                  end else if (run_len[c][i] >= DEPTH && !run_val[c][i] && e_lvl[c][i]) begin
                     e_lvl[c][i] = 1'b0; e_rel[c][i] = 1'b1;
                  end else if (e_lvl[c][i]) begin
                     tsp[c][i]++;
                     if (PER_C[c] != 0 && tsp[c][i] >= DELAY && (tsp[c][i] - DELAY) % PER_C[c] == 0)
                        e_rpt[c][i] = 1'b1;
                  end
               end
            end
         end
         m_s2 = m_s1;
         m_s1 = key_in;
      end
   end

   // Cycle-by-cycle comparison against the model, plus pulse bookkeeping.
   int cyc = 0;
   int press_time0 = 0;
   int n_prs_a [3] = '{0, 0, 0};
   int n_rel_a [3] = '{0, 0, 0};
   int n_rpt_c = 0;
   int rpt_times [$];

   always @(negedge sysclk) begin
      check_bits("model_a", {24'd0, lvl_a, prs_a, rel_a, rpt_a}, {24'd0, e_lvl[0], e_prs[0], e_rel[0], e_rpt[0]});
      check_bits("model_b", {24'd0, lvl_b, prs_b, rel_b, rpt_b}, {24'd0, e_lvl[1], e_prs[1], e_rel[1], e_rpt[1]});
      check_bits("model_c", {24'd0, lvl_c, prs_c, rel_c, rpt_c}, {24'd0, e_lvl[2], e_prs[2], e_rel[2], e_rpt[2]});
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (prs_a[i]) n_prs_a[i]++;
         if (rel_a[i]) n_rel_a[i]++;
         if (rpt_c[i]) n_rpt_c++;
      end
      if (prs_a[0]) press_time0 = cyc;
      if (rpt_a[0]) rpt_times.push_back(cyc);
   end

   function automatic logic [2:0] dbits(input int now_v [3], input int was [3]);
      logic [2:0] r;
      for (int i = 0; i < 3; i++) r[i] = now_v[i] > was[i];
      return r;
   endfunction

   task automatic drive(input logic [2:0] k, input int n);
      key_in = k;
      repeat (n) @(negedge sysclk);
      #1;
   endtask

   typedef struct {
      logic [2:0] key;
      int         cycles;
      logic [2:0] lvl_a;
      logic [2:0] lvl_b;
      logic [2:0] prs_a;
      logic [2:0] rel_a;
   } vec_t;

   vec_t tbl [9];
   int   sp [3];
   int   sr [3];
   int   sz;
   logic [2:0] rk;

   initial begin
      tbl[0] = '{3'b000, 24, 3'b000, 3'b000, 3'b000, 3'b000};
      tbl[1] = '{3'b010, 24, 3'b010, 3'b010, 3'b010, 3'b000};
      tbl[2] = '{3'b000, 24, 3'b000, 3'b000, 3'b000, 3'b010};
      tbl[3] = '{3'b101, 24, 3'b000, 3'b101, 3'b000, 3'b000};
      tbl[4] = '{3'b111, 24, 3'b000, 3'b111, 3'b000, 3'b000};
      tbl[5] = '{3'b001, 24, 3'b001, 3'b001, 3'b001, 3'b000};
      tbl[6] = '{3'b011, 24, 3'b000, 3'b011, 3'b000, 3'b001};
      tbl[7] = '{3'b100, 24, 3'b100, 3'b100, 3'b100, 3'b000};
      tbl[8] = '{3'b000, 24, 3'b000, 3'b000, 3'b000, 3'b100};

      repeat (3) @(negedge sysclk);
      check_bits("reset_state", all_outs(), 36'd0);
      #1 reset = 1'b0;

      for (int r = 0; r < 9; r++) begin
         sp = n_prs_a;
         sr = n_rel_a;
         drive(tbl[r].key, tbl[r].cycles);
         check_bits($sformatf("tbl%0d_lvl_a", r), {33'd0, lvl_a}, {33'd0, tbl[r].lvl_a});
         check_bits($sformatf("tbl%0d_lvl_b", r), {33'd0, lvl_b}, {33'd0, tbl[r].lvl_b});
         check_bits($sformatf("tbl%0d_prs_a", r), {33'd0, dbits(n_prs_a, sp)}, {33'd0, tbl[r].prs_a});
         check_bits($sformatf("tbl%0d_rel_a", r), {33'd0, dbits(n_rel_a, sr)}, {33'd0, tbl[r].rel_a});
      end

      // Long hold: exactly one press, no release.
      sp = n_prs_a; sr = n_rel_a;
      drive(3'b010, 80);
      check_int("hold_press_cnt", n_prs_a[1] - sp[1], 1);
      check_int("hold_rel_cnt", n_rel_a[1] - sr[1], 0);
      check_bits("hold_lvl", {33'd0, lvl_a}, 36'd2);
      drive(3'b000, 24);

      // Bounce every two ticks never settles.
      sp = n_prs_a;
      for (int k = 0; k < 5; k++) begin
         drive(3'b001, 8);
         drive(3'b000, 8);
      end
      check_int("bounce_press", n_prs_a[0] - sp[0], 0);
      check_bits("bounce_lvl", {30'd0, lvl_a, lvl_b}, 36'd0);

      // One-tick dropout is absorbed, a three-tick low releases.
      drive(3'b100, 24);
      sr = n_rel_a;
      drive(3'b000, 4);
      drive(3'b100, 24);
      check_int("glitch_no_rel", n_rel_a[2] - sr[2], 0);
      check_bits("glitch_lvl", {33'd0, lvl_a}, 36'd4);
      drive(3'b000, 24);
      check_int("low_rel", n_rel_a[2] - sr[2], 1);
      check_bits("low_lvl", {33'd0, lvl_a}, 36'd0);

      // Auto-repeat cadence: press+4, +6, +8, +10, +12 ticks.
      sz = rpt_times.size();
      drive(3'b001, 80);
      if (rpt_times.size() < sz + 5) begin
         check_int("rpt_count", rpt_times.size() - sz, 5);
      end else begin
         for (int k = 0; k < 5; k++)
            check_int($sformatf("rpt_off%0d", k), rpt_times[sz + k] - press_time0, 16 + 8 * k);
      end
      check_int("rpt_disabled", n_rpt_c, 0);
      drive(3'b000, 24);

      // Asynchronous reset mid-hold, then a single clean re-press.
      drive(3'b010, 24);
      @(posedge sysclk);
      #2 reset = 1'b1;
      #1 check_bits("reset_async", all_outs(), 36'd0);
      repeat (2) @(negedge sysclk);
      #1 reset = 1'b0;
      sp = n_prs_a; sr = n_rel_a;
      drive(3'b010, 24);
      check_int("repress_cnt", n_prs_a[1] - sp[1], 1);
      check_int("repress_no_rel", n_rel_a[1] - sr[1], 0);
      check_bits("repress_lvl", {33'd0, lvl_a}, 36'd2);

      // Random holds with occasional resets, checked by the model.
      for (int n = 0; n < 200; n++) begin
         rk = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) rk = 3'b001 << $urandom_range(0, 2);
         drive(rk, $urandom_range(1, 40));
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge sysclk);
            #1 reset = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
